// File: rtl/if_id_buffer.sv
// Two-entry elastic buffer between fetch and decode.
// Entry 0 is always the head, so decode sees registered fields.
module if_id_buffer #(
  parameter int PC_W   = 30,
  parameter int INST_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [PC_W+INST_W-1:0] IF_ID_BUS,
  output logic                   if_ready,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [PC_W-1:0]        id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_ctrl_xfer,
  output logic [1:0]             count
);

  logic [1:0]        r_count;
  logic [PC_W-1:0]   r_pc0;
  logic [PC_W-1:0]   r_pc1;
  logic [INST_W-1:0] r_inst0;
  logic [INST_W-1:0] r_inst1;
  logic              r_ctrl0;
  logic              r_ctrl1;

  logic              w_push;
  logic              w_pop;
  logic [PC_W-1:0]   w_in_pc;
  logic [INST_W-1:0] w_in_inst;
  logic [5:0]        w_opcode;
  logic              w_in_ctrl;

  assign w_in_pc   = IF_ID_BUS[PC_W+INST_W-1:INST_W];
  assign w_in_inst = IF_ID_BUS[INST_W-1:0];
  assign w_opcode  = w_in_inst[INST_W-1 -: 6];

  // j, jal, beq, bne
  assign w_in_ctrl = (w_opcode == 6'b000010)
                   | (w_opcode == 6'b000011)
                   | (w_opcode == 6'b000100)
                   | (w_opcode == 6'b000101);

  assign if_ready = (r_count != 2'd2) & ~reset;
  assign id_valid = (r_count != 2'd0);
  assign w_push   = if_valid & if_ready;
  assign w_pop    = id_valid & id_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_pc0   <= '0;
      r_pc1   <= '0;
      r_inst0 <= '0;
      r_inst1 <= '0;
      r_ctrl0 <= 1'b0;
      r_ctrl1 <= 1'b0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0   <= w_in_pc;
            r_inst0 <= w_in_inst;
            r_ctrl0 <= w_in_ctrl;
          end else begin
            r_pc1   <= w_in_pc;
            r_inst1 <= w_in_inst;
            r_ctrl1 <= w_in_ctrl;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc0   <= r_pc1;
          r_inst0 <= r_inst1;
          r_ctrl0 <= r_ctrl1;
          r_count <= r_count - 2'd1;
        end
        // push with pop only happens at count 1
        2'b11: begin
          r_pc0   <= w_in_pc;
          r_inst0 <= w_in_inst;
          r_ctrl0 <= w_in_ctrl;
        end
        default: begin
        end
      endcase
    end
  end

  assign id_pc        = r_pc0;
  assign id_inst      = r_inst0;
  assign id_ctrl_xfer = r_ctrl0;
  assign count        = r_count;

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry elastic buffer between the fetch stage and the decode stage. It captures the fetch output bus {pc, instruction} under a valid/ready handshake, holds up to two words so that fetch can keep running for one cycle after decode stalls, and presents a registered head entry to decode with a one-bit branch/jump pre-decode flag. A redirect flush empties the buffer in one cycle.

## Interface
- PC_W, default 30: word-address PC width.
- INST_W, default 32: instruction width. The bus width is PC_W+INST_W, 62 by default.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  discards all held entries; asserted on jump or branch redirect.
- if_valid  input  1  fetch presents a valid word on IF_ID_BUS.
- IF_ID_BUS  input  PC_W+INST_W  {pc[29:0], inst[31:0]}; the pc occupies the MSBs.
- if_ready  output  1  buffer accepts a word this cycle.
- id_valid  output  1  the head entry is valid.
- id_ready  input  1  decode consumes the head entry this cycle.
- id_pc  output  PC_W  head entry pc.
- id_inst  output  INST_W  head entry instruction.
- id_ctrl_xfer  output  1  head opcode inst[31:26] is one of 000010 (j), 000011 (jal), 000100 (beq) or 000101 (bne).
- count  output  2  number of held entries, 0..2.

## Operation
- Storage:
  - Two entries, each holding {pc, inst, ctrl_xfer}.
  - ctrl_xfer is computed from the incoming inst at write time and stored with the entry.
- Handshakes:
  - push = if_valid & if_ready.
  - pop = id_valid & id_ready.
- if_ready = (count != 2) & ~reset. It depends only on state and reset. There is no combinational path from id_ready to if_ready.
- id_valid = (count != 0). id_pc, id_inst and id_ctrl_xfer always reflect the head entry and are driven straight from registers.
- Count update, with flush taking priority:
  - flush: count goes to 0. A push or pop in the same cycle is ignored and the incoming word is dropped.
  - push only: count increases by 1.
  - pop only: count decreases by 1.
  - push and pop together: count is unchanged. At count 1 the new word becomes the head. At count 2 a push is impossible because if_ready is 0.
- Ordering is strict FIFO. When a pop happens at count 2, the second entry becomes the head on the next edge.
- An all-zero instruction (NOP bubble) is an ordinary entry: it is pushed and popped normally and has id_ctrl_xfer = 0.
- While id_valid & ~id_ready, the head fields must hold stable every cycle.
- Entry payload registers do not need to be cleared on flush. Only count and the valid state matter.
- Reset (asynchronous, any cycle, including mid-transfer):
  - count = 0, id_valid = 0, id_pc = 0, id_inst = 0, id_ctrl_xfer = 0.
  - if_ready = 0 while reset is high.
  - All held entries are lost.

## Timing
- Latency: a word pushed at edge N is visible on the id_* outputs after edge N when the buffer was empty. When one entry is ahead of it, it appears one pop later.
- Throughput: one word per cycle sustained while id_ready = 1.
- Stall absorption: if id_ready drops, fetch can complete one more push (count reaches 2). if_ready then falls the cycle after the second entry is written.
- Flush at edge N: after edge N, id_valid = 0 and if_ready = 1. A push at edge N+1 becomes the head after N+1.
- Reset deassertion: the first push is possible on the first rising edge where reset is low.

## Test plan
- Reset: assert reset mid-stream with count = 2, asynchronously and between edges -> count, id_valid, id_pc and id_inst go to 0 immediately, and if_ready = 0 until reset is released.
- Streaming: push pc 0x10..0x17 with inst 0x20000000+i, id_ready = 1 -> each word appears one cycle after its push, in order, and count stays at 1.
- Backpressure: push pc 0x100, 0x101, 0x102 with id_ready = 0 -> count reaches 2, if_ready = 0, 0x102 is not accepted, and the head stays 0x100. Raise id_ready -> the outputs are 0x100 then 0x101, and only then is 0x102 accepted.
- Simultaneous push and pop at count 1: head pc 0x20 popped while pc 0x21 is pushed -> count stays 1 and id_pc = 0x21 next cycle.
- Flush collisions: with count = 2, assert flush together with if_valid (pc 0x40) and id_ready -> count = 0, id_valid = 0, and pc 0x40 never appears at the output.
- Pre-decode: push inst 0x08000004, 0x10220003, 0x00000000 and 0x8C010000 -> id_ctrl_xfer reads 1, 1, 0, 0 respectively.
